// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register plus operand forwarding for the ALU of the
// pipelined MIPS core. It latches the decoded instruction from ID on every
// rising edge. It loads a bubble on a taken branch (flush) or on a load-use
// hazard, and it takes the freshest ALU operands from the MEM and WB
// producers.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   id_*                               decoded instruction from ID
//   flush                              squash the instruction entering EX
//   mem_reg_write/mem_rd_idx/mem_result  EX/MEM producer (highest priority)
//   wb_reg_write/wb_rd_idx/wb_result     MEM/WB producer
//   alu_opcode, alu_rs, alu_rt         ALU operands
//   ex_valid, ex_rd_idx, ex_reg_write,
//   ex_mem_read, ex_mem_write          control passed to EX/MEM
//   ex_store_data                      forwarded rt value for stores
//   stall_id                           hold PC and IF/ID this cycle
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [2:0]  id_alu_op,
  input  logic [4:0]  id_rs_idx,
  input  logic [4:0]  id_rt_idx,
  input  logic [4:0]  id_rd_idx,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [31:0] id_imm,
  input  logic        id_use_imm,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        flush,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd_idx,
  input  logic [31:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd_idx,
  input  logic [31:0] wb_result,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  output logic        ex_valid,
  output logic [4:0]  ex_rd_idx,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [31:0] ex_store_data,
  output logic        stall_id
);

  logic        valid_q, valid_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [4:0]  rs_idx_q, rs_idx_d;
  logic [4:0]  rt_idx_q, rt_idx_d;
  logic [4:0]  rd_idx_q, rd_idx_d;
  logic [31:0] rs_val_q, rs_val_d;
  logic [31:0] rt_val_q, rt_val_d;
  logic [31:0] imm_q, imm_d;
  logic        use_imm_q, use_imm_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  // A load sitting in EX cannot supply its data until it reaches WB, so an
  // ID instruction reading that register must wait one cycle. The rt port
  // only counts when rt is actually read: as an ALU operand or as store data.
  always_comb begin
    stall_id = id_valid & valid_q & mem_read_q & (rd_idx_q != 5'd0) &
               ((rd_idx_q == id_rs_idx) |
                ((rd_idx_q == id_rt_idx) & (~id_use_imm | id_mem_write)));
  end

  // Flush and stall both load a bubble. Control bits are cleared so that the
  // bubble can never write state downstream. The data fields are don't-care
  // while valid is low.
  always_comb begin
    valid_d     = id_valid;
    alu_op_d    = id_alu_op;
    rs_idx_d    = id_rs_idx;
    rt_idx_d    = id_rt_idx;
    rd_idx_d    = id_rd_idx;
    rs_val_d    = id_rs_val;
    rt_val_d    = id_rt_val;
    imm_d       = id_imm;
    use_imm_d   = id_use_imm;
    reg_write_d = id_reg_write & id_valid;
    mem_read_d  = id_mem_read & id_valid;
    mem_write_d = id_mem_write & id_valid;
    if (flush | stall_id) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      alu_op_q    <= 3'd0;
      rs_idx_q    <= 5'd0;
      rt_idx_q    <= 5'd0;
      rd_idx_q    <= 5'd0;
      rs_val_q    <= 32'd0;
      rt_val_q    <= 32'd0;
      imm_q       <= 32'd0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      alu_op_q    <= alu_op_d;
      rs_idx_q    <= rs_idx_d;
      rt_idx_q    <= rt_idx_d;
      rd_idx_q    <= rd_idx_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // $0 is hardwired to zero. For other registers MEM is the younger producer
  // and therefore takes priority over WB.
  always_comb begin
    if (rs_idx_q == 5'd0)
      rs_fwd = 32'd0;
    else if (mem_reg_write && (mem_rd_idx == rs_idx_q))
      rs_fwd = mem_result;
    else if (wb_reg_write && (wb_rd_idx == rs_idx_q))
      rs_fwd = wb_result;
    else
      rs_fwd = rs_val_q;
  end

  always_comb begin
    if (rt_idx_q == 5'd0)
      rt_fwd = 32'd0;
    else if (mem_reg_write && (mem_rd_idx == rt_idx_q))
      rt_fwd = mem_result;
    else if (wb_reg_write && (wb_rd_idx == rt_idx_q))
      rt_fwd = wb_result;
    else
      rt_fwd = rt_val_q;
  end

  assign alu_rs        = rs_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_rt        = use_imm_q ? imm_q : rt_fwd;
  assign alu_opcode    = valid_q ? alu_op_q : 3'b000;
  assign ex_valid      = valid_q;
  assign ex_rd_idx     = valid_q ? rd_idx_q : 5'd0;
  assign ex_reg_write  = valid_q & reg_write_q;
  assign ex_mem_read   = valid_q & mem_read_q;
  assign ex_mem_write  = valid_q & mem_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding cases
// followed by randomized traffic checked against a behavioural EX model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [2:0]  id_alu_op;
  logic [4:0]  id_rs_idx, id_rt_idx, id_rd_idx;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic        id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_idx;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_result;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_rs, alu_rt, ex_store_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall_id;
  logic [4:0]  ex_rd_idx;

  int testCount = 0;
  int failCount = 0;

  // Behavioural picture of the instruction sitting in EX
  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsVal, rtVal, imm;
    logic        useImm, rw, mr, mw;
  } ExState;

  ExState m;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx), .id_rd_idx(id_rd_idx),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_rd_idx(mem_rd_idx), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_idx(wb_rd_idx), .wb_result(wb_result),
    .alu_opcode(alu_opcode), .alu_rs(alu_rs), .alu_rt(alu_rt),
    .ex_valid(ex_valid), .ex_rd_idx(ex_rd_idx), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .stall_id(stall_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The value an instruction should see for register idx, given what the
  // register file returned and what MEM/WB are currently producing.
  function automatic logic [31:0] regValue(input logic [4:0] idx, input logic [31:0] fileVal);
    if (idx == 0) return 32'd0;
    if (mem_reg_write && mem_rd_idx == idx) return mem_result;
    if (wb_reg_write && wb_rd_idx == idx) return wb_result;
    return fileVal;
  endfunction

  // ID must wait if it reads the destination of a load currently in EX
  function automatic logic expStall();
    logic readsRt;
    readsRt = !id_use_imm || id_mem_write;
    return id_valid && m.valid && m.mr && m.rd != 0 &&
           (m.rd == id_rs_idx || (readsRt && m.rd == id_rt_idx));
  endfunction

  task automatic checkOutput(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
    chk({tag, ".op"}, 32'(alu_opcode), m.valid ? 32'(m.op) : 32'd0);
    chk({tag, ".rd"}, 32'(ex_rd_idx), m.valid ? 32'(m.rd) : 32'd0);
    chk({tag, ".rw"}, 32'(ex_reg_write), 32'(m.valid && m.rw));
    chk({tag, ".mr"}, 32'(ex_mem_read), 32'(m.valid && m.mr));
    chk({tag, ".mw"}, 32'(ex_mem_write), 32'(m.valid && m.mw));
    chk({tag, ".stall"}, 32'(stall_id), 32'(expStall()));
    if (m.valid) begin
      chk({tag, ".rs"}, alu_rs, regValue(m.rs, m.rsVal));
      chk({tag, ".rt"}, alu_rt, m.useImm ? m.imm : regValue(m.rt, m.rtVal));
      chk({tag, ".store"}, ex_store_data, regValue(m.rt, m.rtVal));
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [31:0] rsV, input logic [31:0] rtV, input logic [31:0] imm,
                               input logic useImm, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_alu_op = op;
    id_rs_idx = rs; id_rt_idx = rt; id_rd_idx = rd;
    id_rs_val = rsV; id_rt_val = rtV; id_imm = imm;
    id_use_imm = useImm; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic setProducers(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                              input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
    mem_reg_write = mrw; mem_rd_idx = mrd; mem_result = mres;
    wb_reg_write = wrw; wb_rd_idx = wrd; wb_result = wres;
  endtask

  // One clock: advance the model with the inputs present before the edge
  task automatic tick();
    ExState n;
    logic st;
    st = expStall();
    n = m;
    if (flush || st) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0;
    end else begin
      n.valid = id_valid; n.op = id_alu_op;
      n.rs = id_rs_idx; n.rt = id_rt_idx; n.rd = id_rd_idx;
      n.rsVal = id_rs_val; n.rtVal = id_rt_val; n.imm = id_imm;
      n.useImm = id_use_imm;
      n.rw = id_reg_write && id_valid;
      n.mr = id_mem_read && id_valid;
      n.mw = id_mem_write && id_valid;
    end
    @(posedge clk);
    m = n;
    @(negedge clk);
    #1;
  endtask

  initial begin
    m = '{default: '0};
    rst_n = 1'b0;
    flush = 1'b0;
    applyStimulus(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setProducers(0, 0, 0, 0, 0, 0);
    #12;
    checkOutput("reset");
    chk("reset.alu_rt", alu_rt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MEM forwarding beats WB and the register file
    applyStimulus(1, 3'b010, 1, 2, 3, 32'h5, 32'h6, 0, 0, 1, 0, 0);
    tick();
    setProducers(1, 1, 32'h11, 1, 1, 32'h22);
    #1;
    chk("memfwd.alu_rs", alu_rs, 32'h11);
    chk("memfwd.alu_rt", alu_rt, 32'h6);
    chk("memfwd.op", 32'(alu_opcode), 32'h2);
    chk("memfwd.rd", 32'(ex_rd_idx), 32'd3);
    checkOutput("memfwd");

    // WB forwarding on rt when MEM targets a different register
    setProducers(1, 1, 32'h11, 1, 2, 32'h7);
    #1;
    chk("wbfwd.alu_rt", alu_rt, 32'h7);
    chk("wbfwd.store", ex_store_data, 32'h7);

    // $0 never forwards
    applyStimulus(1, 3'b001, 0, 2, 6, 32'h1234, 32'h9, 0, 0, 1, 0, 0);
    tick();
    setProducers(1, 0, 32'h55, 0, 0, 0);
    #1;
    chk("zero.alu_rs", alu_rs, 32'd0);
    checkOutput("zero");

    // Load-use: lw $4 in EX, sub reading $4 in ID
    setProducers(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3'b010, 0, 0, 4, 0, 0, 32'h10, 1, 1, 1, 0);
    tick();
    applyStimulus(1, 3'b110, 4, 5, 7, 32'hDEAD, 32'h3, 0, 0, 1, 0, 0);
    #1;
    chk("loaduse.stall", 32'(stall_id), 32'd1);
    tick();
    chk("loaduse.bubble", 32'(ex_valid), 32'd0);
    chk("loaduse.release", 32'(stall_id), 32'd0);
    tick();
    setProducers(0, 0, 0, 1, 4, 32'h99);
    #1;
    chk("loaduse.alu_rs", alu_rs, 32'h99);
    chk("loaduse.op", 32'(alu_opcode), 32'h6);
    checkOutput("loaduse");

    // Immediate operand replaces rt on the ALU but not on store data
    setProducers(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3'b111, 1, 2, 8, 32'h1, 32'h33, 32'hFFFFFFFC, 1, 1, 0, 0);
    tick();
    chk("imm.alu_rt", alu_rt, 32'hFFFFFFFC);
    chk("imm.store", ex_store_data, 32'h33);

    // Flush squashes the incoming add
    applyStimulus(1, 3'b010, 1, 2, 3, 32'h5, 32'h6, 0, 0, 1, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush.valid", 32'(ex_valid), 32'd0);
    chk("flush.rw", 32'(ex_reg_write), 32'd0);
    chk("flush.op", 32'(alu_opcode), 32'd0);

    // Flush together with a load-use stall
    applyStimulus(1, 3'b010, 0, 0, 4, 0, 0, 32'h10, 1, 1, 1, 0);
    tick();
    applyStimulus(1, 3'b010, 4, 2, 9, 32'h1, 32'h2, 0, 0, 1, 0, 0);
    flush = 1'b1;
    #1;
    chk("flushstall.stall", 32'(stall_id), 32'd1);
    tick();
    flush = 1'b0;
    chk("flushstall.valid", 32'(ex_valid), 32'd0);

    // Asynchronous reset in the middle of a valid instruction
    applyStimulus(1, 3'b010, 1, 2, 3, 32'h5, 32'h6, 0, 0, 1, 0, 0);
    tick();
    chk("prereset.valid", 32'(ex_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    m = '{default: '0};
    #1;
    chk("async.valid", 32'(ex_valid), 32'd0);
    chk("async.op", 32'(alu_opcode), 32'd0);
    chk("async.rs", alu_rs, 32'd0);
    chk("async.rt", alu_rt, 32'd0);
    chk("async.rw", 32'(ex_reg_write), 32'd0);
    checkOutput("async");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tick();
    chk("postreset.valid", 32'(ex_valid), 32'd1);
    chk("postreset.op", 32'(alu_opcode), 32'h2);

    // Randomized traffic with a small register window so hazards are common
    for (int i = 0; i < 400; i++) begin
      if (!expStall()) begin
        applyStimulus($urandom_range(0, 3) != 0, 3'($urandom), 5'($urandom_range(0, 5)),
                      5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), $urandom, $urandom,
                      $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
      end
      flush = ($urandom_range(0, 7) == 0);
      setProducers($urandom_range(0, 1) == 1, 5'($urandom_range(0, 5)), $urandom,
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 5)), $urandom);
      #1;
      checkOutput("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-forwarding stage that directly feeds the ALU (opcode, rs, rt) in the pipelined MIPS core. It captures decoded instructions from ID each cycle. It resolves RAW hazards by forwarding from MEM and WB, and detects load-use hazards to stall ID and insert a bubble. Branch flush kills the instruction being latched.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits, ALU opcode 3 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  3  ALU opcode: 000 and, 001 or, 010 add, 110 sub, 111 slt
- id_rs_idx, id_rt_idx, id_rd_idx  in  5 each  source/destination register numbers
- id_rs_val, id_rt_val  in  32 each  register-file read data
- id_imm  in  32  sign-extended immediate
- id_use_imm  in  1  ALU rt operand is id_imm, not rt register
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- flush  in  1  branch/jump resolved taken; squash instruction entering EX
- mem_reg_write  in  1, mem_rd_idx  in  5, mem_result  in  32  EX/MEM producer
- wb_reg_write  in  1, wb_rd_idx  in  5, wb_result  in  32  MEM/WB producer
- alu_opcode  out  3, alu_rs  out  32, alu_rt  out  32  ALU operands
- ex_valid  out  1  EX holds a real instruction
- ex_rd_idx  out  5, ex_reg_write  out  1, ex_mem_read  out  1, ex_mem_write  out  1  control to EX/MEM
- ex_store_data  out  32  forwarded rt register value for stores
- stall_id  out  1  hold PC and IF/ID this cycle

## Operation
- Registered state: valid, alu_op, rs/rt/rd idx, rs/rt values, imm, use_imm, reg_write, mem_read, mem_write.
- Load-use: stall_id = id_valid & ex_valid & ex_mem_read & ex_rd_idx≠0 & (ex_rd_idx==id_rs_idx | (ex_rd_idx==id_rt_idx & (~id_use_imm | id_mem_write))). Combinational.
- Capture each rising edge:
  - flush=1: load bubble (valid=0, reg_write=mem_read=mem_write=0). Flush wins over stall; stall_id is still reported combinationally.
  - else stall_id=1: load bubble. ID holds, so the same instruction re-presents next cycle.
  - else: load all id_* fields; valid=id_valid. Control bits are gated by id_valid.
- Forwarding, combinational, per operand (rs and rt independently), using registered idx:
  - idx==0 → 0.
  - mem_reg_write & mem_rd_idx==idx → mem_result (priority).
  - else wb_reg_write & wb_rd_idx==idx → wb_result.
  - else registered value.
- alu_rs = fwd(rs); ex_store_data = fwd(rt); alu_rt = use_imm ? imm : fwd(rt).
- alu_opcode = registered alu_op when valid, else 3'b000.
- ex_* control outputs are registered values; all are 0 when valid=0.
- No stage-internal arithmetic; widths pass through unchanged.

## Timing
- Reset (async assert, sync release on clk): all registers 0. Therefore ex_valid=0, alu_opcode=000, alu_rs=0, ex_rd_idx=0, all control outputs 0.
- alu_rt/ex_store_data follow forwarding from the reset state, e.g. alu_rt=wb_result if wb matches idx 0. Never: idx 0 forced to 0.
- Reset mid-stall: bubble state, stall_id recomputed from zeroed EX → 0.
- Latency: one cycle ID→EX. Forwarded operands are valid in the same cycle the MEM/WB inputs are.
- Load-use stall lasts exactly one cycle. The next cycle EX holds the bubble, the load is in MEM, and MEM forwarding from a load is not used (the load result forwards from WB).
- Simultaneous flush and stall: bubble inserted, the stalled ID instruction is discarded upstream by flush.
- Back-to-back loads with a dependent third instruction: stall only against the load in EX.

## Test plan
- Reset: rst_n=0 mid-run with ex_valid=1 → all outputs 0 immediately without a clock edge; after release, first id_valid add latched next edge.
- MEM forward: EX add $3=$1+$2 (opcode 010). MEM reg_write rd=1 result=0x11, WB rd=1 result=0x22, regfile 0x5 → alu_rs=0x11.
- WB forward and $0: MEM rd=1 (idx 2 unused), WB rd=2 result=7 → alu_rt=7. Instruction with rs=0, MEM rd=0 result=0x55 → alu_rs=0.
- Load-use: EX lw rd=4; ID sub rs=4 → stall_id=1; next edge ex_valid=0. Following cycle sub latched, stall_id=0; WB result 0x99 for rd 4 → alu_rs=0x99.
- Immediate: id_use_imm=1, imm=0xFFFFFFFC, slt → alu_rt=0xFFFFFFFC; ex_store_data still forwarded rt value.
- Flush: flush=1 with id_valid add → next edge ex_valid=0, ex_reg_write=0, alu_opcode=000; same with stall_id=1 → bubble.
